// File: rtl/uart_frame_tx.sv
// UART frame serializer: valid/ready byte in, 8N1 (optional even parity) bitstream out, one bit per clock.
// Optional parity bit enabled by defining UART_FRAME_TX_PARITY_EN.
module uart_frame_tx #(
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned GAP_BITS  = 0
) (
    input  logic        clk_uart_tx,
    input  logic        rst_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] frame_cnt_o
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned FCNT_W = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
`ifdef UART_FRAME_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);
    localparam logic             HAS_GAP   = (GAP_BITS != 0);

    if (STOP_BITS == 0 || STOP_BITS > 2 || GAP_BITS > 15) begin : g_param_err
        $error("uart_frame_tx: STOP_BITS must be 1 or 2 and GAP_BITS must be 0..15");
    end

    logic [2:0]        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic              r_tx, w_tx_nxt;
    logic [FCNT_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
`ifdef UART_FRAME_TX_PARITY_EN
    logic              r_parity, w_parity_nxt;
`endif
    logic              w_final;
    logic              w_accept;

    // Final bit time: last stop bit when there is no gap, else last gap bit.
    assign w_final = ((r_state == S_STOP) && (r_bit_cnt == STOP_LAST) && !HAS_GAP)
                   || ((r_state == S_GAP) && (r_bit_cnt == GAP_LAST) && HAS_GAP);

    assign ready_o     = (r_state == S_IDLE) || w_final;
    assign w_accept    = valid_i && ready_o;
    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = w_final;
    assign tx_o        = r_tx;
    assign frame_cnt_o = r_frame_cnt;

    always_ff @(posedge clk_uart_tx or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_tx        <= 1'b1;
            r_frame_cnt <= '0;
`ifdef UART_FRAME_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_tx        <= w_tx_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
`ifdef UART_FRAME_TX_PARITY_EN
            r_parity    <= w_parity_nxt;
`endif
        end
    end

    // Next state and the value tx_o will carry in the next bit time.
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_tx_nxt        = r_tx;
        w_frame_cnt_nxt = r_frame_cnt;
`ifdef UART_FRAME_TX_PARITY_EN
        w_parity_nxt    = r_parity;
`endif

        if (w_final) begin
            w_frame_cnt_nxt = r_frame_cnt + 16'd1;
        end

        if (w_accept) begin
            w_state_nxt   = S_START;
            w_bit_cnt_nxt = '0;
            w_shift_nxt   = data_i;
            w_tx_nxt      = 1'b0;
`ifdef UART_FRAME_TX_PARITY_EN
            w_parity_nxt  = ^data_i;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_tx_nxt = 1'b1;
                end
                S_START: begin
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = '0;
                    w_tx_nxt      = r_shift[0];
                    w_shift_nxt   = {1'b0, r_shift[DATA_W-1:1]};
                end
                S_DATA: begin
                    if (r_bit_cnt == DATA_LAST) begin
                        w_bit_cnt_nxt = '0;
`ifdef UART_FRAME_TX_PARITY_EN
                        w_state_nxt   = S_PARITY;
                        w_tx_nxt      = r_parity;
`else
                        w_state_nxt   = S_STOP;
                        w_tx_nxt      = 1'b1;
`endif
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        w_tx_nxt      = r_shift[0];
                        w_shift_nxt   = {1'b0, r_shift[DATA_W-1:1]};
                    end
                end
`ifdef UART_FRAME_TX_PARITY_EN
                S_PARITY: begin
                    w_state_nxt   = S_STOP;
                    w_bit_cnt_nxt = '0;
                    w_tx_nxt      = 1'b1;
                end
`endif
                S_STOP: begin
                    w_tx_nxt = 1'b1;
                    if (r_bit_cnt == STOP_LAST) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = HAS_GAP ? S_GAP : S_IDLE;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end
                S_GAP: begin
                    w_tx_nxt = 1'b1;
                    if (r_bit_cnt == GAP_LAST) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_bit_cnt_nxt = '0;
                    w_tx_nxt      = 1'b1;
                end
            endcase
        end
    end

endmodule
